stereo_peak_window: RTL and testbench
=====================================

# stereo_peak_window

Windowed stereo peak detector. It consumes the joined left/right sample stream produced by the two-input dataflow join, which combines the per-channel valid/ready streams. For each channel it tracks the largest absolute sample value over a fixed window of WINDOW_LEN accepted sample pairs, then emits the peak pair on a valid/ready output feeding the meter display logic. Full throughput: one sample pair per clock, with no bubbles at window boundaries unless the output is back-pressured.

## Interface
- DATA_WIDTH, 16: width of signed two's-complement input samples; must be ≥ 2.
- WINDOW_LEN, 1024: sample pairs per window; must be ≥ 2. Counter width is $clog2(WINDOW_LEN).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  sample pair valid (from join o_valid).
- i_ready  output  1  sample pair accepted when i_valid && i_ready (to join o_ready).
- i_data_l  input  DATA_WIDTH  left sample, signed.
- i_data_r  input  DATA_WIDTH  right sample, signed.
- o_valid  output  1  peak pair valid.
- o_ready  input  1  downstream ready; transfer when o_valid && o_ready.
- o_peak_l  output  DATA_WIDTH-1  left peak magnitude, unsigned.
- o_peak_r  output  DATA_WIDTH-1  right peak magnitude, unsigned.

## Operation
- Magnitude: mag(x) = -x for x < 0, else x. Result is saturated to 2^(DATA_WIDTH-1)-1, so -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1)-1 and the result fits in DATA_WIDTH-1 bits.
- Internal state:
  - acc_l, acc_r (DATA_WIDTH-1 bits): running peak for each channel.
  - cnt (0..WINDOW_LEN-1): accepted pairs in the current window.
  - Output slot: EMPTY (o_valid=0) or FULL (o_valid=1).
- On accept with cnt < WINDOW_LEN-1: acc_x <= max(acc_x, mag(i_data_x)); cnt <= cnt+1.
- On accept with cnt == WINDOW_LEN-1 (window close):
  - o_peak_x <= max(acc_x, mag(i_data_x)).
  - Slot becomes FULL.
  - acc_x <= 0; cnt <= 0.
- Output slot transitions:
  - EMPTY→FULL on window close.
  - FULL→EMPTY on o_ready with no simultaneous window close.
  - FULL→FULL, reloaded with the new peaks, on o_ready together with a window close. The old pair is transferred and the new pair is presented the next cycle.
- i_ready = !(o_valid && !o_ready && cnt == WINDOW_LEN-1).
  - A pending output blocks only the sample that would close the next window.
  - Mid-window samples keep accumulating while the output is back-pressured.
- o_peak_l/o_peak_r are stable while o_valid=1 and o_ready=0. o_valid never drops without a transfer.
- No partial-window output. A window is emitted only after exactly WINDOW_LEN accepted pairs.

## Timing
- Reset (asynchronous assert, synchronous-release usage assumed by the system) forces:
  - o_valid=0, o_peak_l=0, o_peak_r=0.
  - acc_l=acc_r=0, cnt=0.
  - i_ready=1 (combinational from state after reset).
- Reset mid-window discards the partial window and any pending output. There is no emission after release until WINDOW_LEN new pairs are accepted.
- Latency: o_valid rises one clock after the edge that accepts the closing sample.
- i_ready is combinational from o_ready, o_valid and cnt. There is no combinational path from i_valid or data to any output.
- Throughput: one pair/clock sustained while o_ready is held high. Output rate is one pair per WINDOW_LEN accepted inputs.
- i_valid low or i_ready low: no state change except output-side transfer.

## Test plan
- WINDOW_LEN=4, DATA_WIDTH=16: L = {3, -7, 5, 2}, R = {-1, 0, 100, -100}, o_ready=1 → one output, o_peak_l=7, o_peak_r=100, o_valid high for exactly one cycle, asserted one clock after the 4th accept.
- Saturation: L = {-32768, 0, 0, 0}, R = {32767, -32767, 0, 0} → o_peak_l=32767, o_peak_r=32767.
- Back-pressure: o_ready=0 after the first window closes; stream 3 more pairs → all accepted, i_ready drops at cnt=3, o_peak holds its first-window values. Raise o_ready → first window transfers, 4th pair accepted the same cycle, second window presented the next cycle.
- Continuous streaming, o_ready=1, i_valid=1 for 12 cycles → exactly 3 outputs, i_ready never low, consecutive windows independent (acc cleared, e.g. loud window followed by all-zero window → second peak 0).
- Reset mid-window: accept 2 pairs containing 500, assert i_reset_n=0 for one cycle → o_valid=0 and peaks 0 immediately. Next 4 pairs of value 1 → peak 1, not 500.
- Gapped input: i_valid toggled randomly, o_ready toggled randomly, random data → outputs match a reference model. No dropped or duplicated windows; o_peak stable while stalled.

Source files
------------

// File: rtl/stereo_peak_window.sv
// Purpose : windowed stereo peak detector; tracks the largest |sample| per channel over WINDOW_LEN accepted pairs.
// Latency : o_valid rises one clock after the edge that accepts the window-closing pair.
// Backpres: a pending unaccepted output stalls only the next window-closing pair; mid-window pairs keep flowing.
//
// Ports:
//   i_clk, i_reset_n      clock (rising edge) and asynchronous active-low reset
//   i_valid/i_ready       input sample-pair handshake (i_ready is combinational from o_ready and state only)
//   i_data_l, i_data_r    signed two's-complement left/right samples
//   o_valid/o_ready       output peak-pair handshake
//   o_peak_l, o_peak_r    unsigned saturated peak magnitudes (DATA_WIDTH-1 bits)
module stereo_peak_window #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW_LEN = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data_l,
    input  logic [DATA_WIDTH-1:0] i_data_r,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-2:0] o_peak_l,
    output logic [DATA_WIDTH-2:0] o_peak_r
);

    localparam int CW = $clog2(WINDOW_LEN);
    localparam int MW = DATA_WIDTH - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW_LEN - 1);

    // Absolute value, saturating the most negative code to the largest positive magnitude
    // so the result always fits in DATA_WIDTH-1 bits.
    function automatic logic [MW-1:0] mag(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] neg;
        neg = DATA_WIDTH'(0) - x;
        if (!x[DATA_WIDTH-1]) begin
            return x[MW-1:0];
        end else if (neg[DATA_WIDTH-1]) begin
            return '1;
        end else begin
            return neg[MW-1:0];
        end
    endfunction

    logic [MW-1:0] acc_l_q, acc_l_d;
    logic [MW-1:0] acc_r_q, acc_r_d;
    logic [MW-1:0] peak_l_q, peak_l_d;
    logic [MW-1:0] peak_r_q, peak_r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;

    logic [MW-1:0] mag_l, mag_r;
    logic [MW-1:0] max_l, max_r;
    logic          cnt_last;
    logic          accept;
    logic          win_close;

    always_comb begin
        mag_l     = mag(i_data_l);
        mag_r     = mag(i_data_r);
        max_l     = (acc_l_q > mag_l) ? acc_l_q : mag_l;
        max_r     = (acc_r_q > mag_r) ? acc_r_q : mag_r;
        cnt_last  = (cnt_q == CNT_LAST);
        // Only the closing pair needs the output slot; it is held off while the slot is stuck full.
        i_ready   = !(vld_q && !o_ready && cnt_last);
        accept    = i_valid && i_ready;
        win_close = accept && cnt_last;
    end

    always_comb begin
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        cnt_d    = cnt_q;
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        // A close can only happen when the slot is empty or draining this cycle,
        // so reloading the slot never overwrites an untransferred pair.
        vld_d    = win_close || (vld_q && !o_ready);

        if (accept) begin
            if (cnt_last) begin
                acc_l_d  = '0;
                acc_r_d  = '0;
                cnt_d    = '0;
                peak_l_d = max_l;
                peak_r_d = max_r;
            end else begin
                acc_l_d  = max_l;
                acc_r_d  = max_r;
                cnt_d    = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            cnt_q    <= '0;
            peak_l_q <= '0;
            peak_r_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            cnt_q    <= cnt_d;
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
            vld_q    <= vld_d;
        end
    end

    assign o_valid  = vld_q;
    assign o_peak_l = peak_l_q;
    assign o_peak_r = peak_r_q;

endmodule

// File: tb/tb_stereo_peak_window.sv
// Purpose : directed and randomized checks of stereo_peak_window with WINDOW_LEN=4, DATA_WIDTH=16.
// Latency : inputs driven mid-low-phase, handshake sampled before the rising edge, outputs after it.
// Backpres: o_ready driven directly by the stimulus steps.
module tb_stereo_peak_window;

    localparam int DW = 16;
    localparam int WL = 4;

    logic          i_clk;
    logic          i_reset_n;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data_l;
    logic [DW-1:0] i_data_r;
    logic          o_valid;
    logic          o_ready;
    logic [DW-2:0] o_peak_l;
    logic [DW-2:0] o_peak_r;

    int n_cmp  = 0;
    int n_fail = 0;

    // Values captured just before the rising edge of the last step.
    logic          pre_rdy;
    logic          pre_vld;
    logic [DW-2:0] pre_pl;
    logic [DW-2:0] pre_pr;

    stereo_peak_window #(.DATA_WIDTH(DW), .WINDOW_LEN(WL)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data_l  (i_data_l),
        .i_data_r  (i_data_r),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_peak_l  (o_peak_l),
        .o_peak_r  (o_peak_r)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, sample pre-edge handshake, cross the edge, land on the falling edge.
    task automatic cyc(input logic v, input int l, input int r, input logic ordy);
        i_valid  = v;
        i_data_l = DW'(l);
        i_data_r = DW'(r);
        o_ready  = ordy;
        #1;
        pre_rdy = i_ready;
        pre_vld = o_valid;
        pre_pl  = o_peak_l;
        pre_pr  = o_peak_r;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic int tb_mag(input logic [DW-1:0] x);
        int s;
        s = int'($signed(x));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    int cl [12] = '{1000, -20, 300, 7, 0, 0, 0, 0, 5, -9, 2, 0};
    int cr [12] = '{-2000, 40, 0, 1, 0, 0, 0, 0, -6, 3, 0, 4};
    int el [3]  = '{1000, 0, 9};
    int er [3]  = '{2000, 0, 6};

    initial begin
        int n_out;
        int n_rdy_low;
        int m_accl, m_accr, m_cnt, m_pl, m_pr;
        logic m_vld;
        logic m_rdy;
        logic v, ordy;
        logic [DW-1:0] dl, dr;

        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data_l  = '0;
        i_data_r  = '0;
        o_ready   = 1'b0;
        #3;
        chk("reset_o_valid", 32'(o_valid), 0);
        chk("reset_peak_l", 32'(o_peak_l), 0);
        chk("reset_peak_r", 32'(o_peak_r), 0);
        chk("reset_i_ready", 32'(i_ready), 1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Basic window
        cyc(1, 3, -1, 1);
        cyc(1, -7, 0, 1);
        cyc(1, 5, 100, 1);
        chk("basic_no_early_valid", 32'(o_valid), 0);
        cyc(1, 2, -100, 1);
        chk("basic_valid", 32'(o_valid), 1);
        chk("basic_peak_l", 32'(o_peak_l), 7);
        chk("basic_peak_r", 32'(o_peak_r), 100);
        cyc(0, 0, 0, 1);
        chk("basic_valid_one_cycle", 32'(o_valid), 0);

        // Saturation window, then back-pressure on its result
        cyc(1, -32768, 32767, 1);
        cyc(1, 0, -32767, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("sat_valid", 32'(o_valid), 1);
        chk("sat_peak_l", 32'(o_peak_l), 32767);
        chk("sat_peak_r", 32'(o_peak_r), 32767);
        cyc(1, 10, -20, 0);
        chk("bp_rdy_mid0", 32'(pre_rdy), 1);
        cyc(1, 0, 0, 0);
        chk("bp_rdy_mid1", 32'(pre_rdy), 1);
        cyc(1, -30, 5, 0);
        chk("bp_rdy_mid2", 32'(pre_rdy), 1);
        chk("bp_hold_l", 32'(o_peak_l), 32767);
        chk("bp_hold_r", 32'(o_peak_r), 32767);
        cyc(1, 4, 50, 0);
        chk("bp_rdy_blocked", 32'(pre_rdy), 0);
        chk("bp_still_valid", 32'(o_valid), 1);
        chk("bp_stable_l", 32'(o_peak_l), 32767);
        cyc(1, 4, 50, 1);
        chk("bp_rdy_release", 32'(pre_rdy), 1);
        chk("bp_transfer_old", 32'(pre_pl), 32767);
        chk("bp_second_valid", 32'(o_valid), 1);
        chk("bp_second_l", 32'(o_peak_l), 30);
        chk("bp_second_r", 32'(o_peak_r), 50);
        cyc(0, 0, 0, 1);
        chk("bp_drained", 32'(o_valid), 0);

        // Continuous streaming, three back-to-back windows
        n_out = 0;
        n_rdy_low = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, cl[i], cr[i], 1);
            if (!pre_rdy) n_rdy_low++;
            if (o_valid) n_out++;
            if ((i % 4) == 3) begin
                chk($sformatf("stream_valid_w%0d", i / 4), 32'(o_valid), 1);
                chk($sformatf("stream_l_w%0d", i / 4), 32'(o_peak_l), 32'(el[i / 4]));
                chk($sformatf("stream_r_w%0d", i / 4), 32'(o_peak_r), 32'(er[i / 4]));
            end
        end
        cyc(0, 0, 0, 1);
        if (o_valid) n_out++;
        chk("stream_out_count", 32'(n_out), 3);
        chk("stream_rdy_never_low", 32'(n_rdy_low), 0);

        // Reset mid-window (peaks currently hold 9/6 from the last window)
        cyc(1, 500, -500, 1);
        cyc(1, 1, 1, 1);
        i_reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 0);
        chk("rst_mid_peak_l", 32'(o_peak_l), 0);
        chk("rst_mid_peak_r", 32'(o_peak_r), 0);
        cyc(0, 0, 0, 1);
        i_reset_n = 1'b1;
        cyc(1, 1, 1, 1);
        cyc(1, 1, 1, 1);
        cyc(1, 1, 1, 1);
        chk("rst_no_partial", 32'(o_valid), 0);
        cyc(1, 1, -1, 1);
        chk("rst_after_valid", 32'(o_valid), 1);
        chk("rst_after_l", 32'(o_peak_l), 1);
        chk("rst_after_r", 32'(o_peak_r), 1);
        cyc(0, 0, 0, 1);

        // Randomized gapped traffic against a behavioral model
        m_accl = 0; m_accr = 0; m_cnt = 0; m_pl = 1; m_pr = 1; m_vld = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v    = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 3) != 0 ? 1 : 0);
            dl   = DW'($urandom);
            dr   = DW'($urandom);
            if ((i % 37) == 0) dl = 16'h8000;
            m_rdy = !(m_vld && !ordy && m_cnt == WL - 1);
            cyc(v, int'($signed(dl)), int'($signed(dr)), ordy);
            chk("rnd_i_ready", 32'(pre_rdy), 32'(m_rdy));
            chk("rnd_o_valid", 32'(pre_vld), 32'(m_vld));
            if (m_vld) begin
                chk("rnd_peak_l", 32'(pre_pl), 32'(m_pl));
                chk("rnd_peak_r", 32'(pre_pr), 32'(m_pr));
            end
            if (m_vld && ordy) m_vld = 1'b0;
            if (v && m_rdy) begin
                if (tb_mag(dl) > m_accl) m_accl = tb_mag(dl);
                if (tb_mag(dr) > m_accr) m_accr = tb_mag(dr);
                if (m_cnt == WL - 1) begin
                    m_pl = m_accl; m_pr = m_accr; m_vld = 1'b1;
                    m_accl = 0; m_accr = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
